// File: rtl/shift_add_mult_p_if.sv
// Handshake and data bundle for the sequential shift-add multiplier.
//   start  : request a multiply (sampled on the rising edge, honoured only when idle)
//   sgn    : 1 = operands are two's complement, 0 = unsigned
//   x, y   : multiplicand / multiplier, sampled with an accepted start
//   busy   : operation in progress
//   done   : one-cycle pulse, result valid in that cycle
//   result : 2*WIDTH-bit product, held until the next done
interface shift_add_mult_p_if #(
  parameter int unsigned WIDTH = 8
);

  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  // Requester side: issues operands, observes status and product
  modport master (
    output start, sgn, x, y,
    input  busy, done, result
  );

  // Multiplier side
  modport slave (
    input  start, sgn, x, y,
    output busy, done, result
  );

endinterface

// File: rtl/shift_add_mult_p.sv
// Parametrised sequential shift-and-add multiplier, one multiplier bit per clock.
// Signed operation multiplies magnitudes and negates the product at the end.
// Latency from accepting edge to done edge is WIDTH+1 clocks; all outputs registered.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_add_mult_p_if slave (start/sgn/x/y in, busy/done/result out)
module shift_add_mult_p #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_add_mult_p_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplr;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic             neg;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    result_q;

  // Magnitude of an operand; -2^(WIDTH-1) maps onto itself, which is correct unsigned
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  logic [WIDTH-1:0] x_mag_c;
  logic [WIDTH-1:0] y_mag_c;
  logic             neg_c;

  // Operand preprocessing for the accepting edge
  always_comb begin
    x_mag_c = mag(bus.x, bus.sgn);
    y_mag_c = mag(bus.y, bus.sgn);
    neg_c   = bus.sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
  end

  // Controller and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      mplr     <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, x_mag_c};
            mplr   <= y_mag_c;
            neg    <= neg_c;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          // Magnitude product of WIDTH-bit values fits in PW bits, so no carry out
          if (mplr[0]) begin
            acc <= acc + mcand;
          end
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          result_q <= neg ? (~acc + PW'(1)) : acc;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Status invariants: done never overlaps busy and is a single-cycle pulse
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));
  a_done_pulse:    assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

endmodule

// File: tb/tb_shift_add_mult_p.sv
// Directed and randomized checks of shift_add_mult_p at WIDTH = 4, 8 and 16.
module tb_shift_add_mult_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  shift_add_mult_p_if #(.WIDTH(4))  b4 ();
  shift_add_mult_p_if #(.WIDTH(8))  b8 ();
  shift_add_mult_p_if #(.WIDTH(16)) b16 ();

  shift_add_mult_p #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  shift_add_mult_p #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  shift_add_mult_p #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      4: begin b4.start = st; b4.sgn = s; b4.x = a[3:0]; b4.y = b[3:0]; end
      8: begin b8.start = st; b8.sgn = s; b8.x = a[7:0]; b8.y = b[7:0]; end
      default: begin b16.start = st; b16.sgn = s; b16.x = a[15:0]; b16.y = b[15:0]; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      4:       return b4.done;
      8:       return b8.done;
      default: return b16.done;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return b4.busy;
      8:       return b8.busy;
      default: return b16.busy;
    endcase
  endfunction

  function automatic logic [63:0] get_res(input int w);
    case (w)
      4:       return 64'(b4.result);
      8:       return 64'(b8.result);
      default: return 64'(b16.result);
    endcase
  endfunction

  // One-cycle start; edges = clocks from accepting edge to done edge
  task automatic op(input string tag, input int w, input logic s,
                    input logic [31:0] a, input logic [31:0] b,
                    output logic [63:0] r, output int edges, output int busy_cyc);
    @(negedge clk); drive(w, 1'b1, s, a, b);
    @(negedge clk); drive(w, 1'b0, s, a, b);
    edges = 0;
    busy_cyc = 0;
    while (!get_done(w) && edges < 40) begin
      if (get_busy(w)) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    if (!get_done(w)) chk({tag, "_timeout"}, 64'(get_done(w)), 64'd1);
    r = get_res(w);
  endtask

  logic [63:0] r;
  int          e;
  int          bc;
  int          n;

  initial begin
    drive(4, 1'b0, 1'b0, 0, 0);
    drive(8, 1'b0, 1'b0, 0, 0);
    drive(16, 1'b0, 1'b0, 0, 0);
    #2;
    chk("rst_busy",   64'(b8.busy), 64'd0);
    chk("rst_done",   64'(b8.done), 64'd0);
    chk("rst_result", get_res(8),   64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic unsigned op with timing and hold
    op("u13x11", 8, 1'b0, 13, 11, r, e, bc);
    chk("u13x11_res",  r, 64'h008F);
    chk("u13x11_lat",  64'(e), 64'd9);
    chk("u13x11_busy", 64'(bc), 64'd9);
    @(negedge clk);
    chk("u13x11_done_drop", 64'(b8.done), 64'd0);
    chk("u13x11_busy_idle", 64'(b8.busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("u13x11_hold", get_res(8), 64'h008F);

    // Unsigned corners
    op("u255x255", 8, 1'b0, 255, 255, r, e, bc); chk("u255x255", r, 64'hFE01);
    op("u0x200",   8, 1'b0, 0, 200, r, e, bc);   chk("u0x200",   r, 64'h0000);
    op("u200x0",   8, 1'b0, 200, 0, r, e, bc);   chk("u200x0",   r, 64'h0000);
    op("u1x1",     8, 1'b0, 1, 1, r, e, bc);     chk("u1x1",     r, 64'h0001);

    // Signed cases
    op("sm3x5",     8, 1'b1, 32'hFD, 32'h05, r, e, bc); chk("sm3x5",     r, 64'hFFF1);
    op("sm128xm128", 8, 1'b1, 32'h80, 32'h80, r, e, bc); chk("sm128xm128", r, 64'h4000);
    op("sm128x127", 8, 1'b1, 32'h80, 32'h7F, r, e, bc); chk("sm128x127", r, 64'hC080);
    op("s127xm1",   8, 1'b1, 32'h7F, 32'hFF, r, e, bc); chk("s127xm1",   r, 64'hFF81);

    // Handshake: start while busy ignored, then held start gives back-to-back ops
    @(negedge clk); drive(8, 1'b1, 1'b0, 7, 6);
    @(negedge clk); drive(8, 1'b0, 1'b0, 7, 6);
    @(negedge clk);
    @(negedge clk); drive(8, 1'b1, 1'b0, 9, 9);
    @(negedge clk); drive(8, 1'b1, 1'b0, 2, 3);
    n = 3;
    while (!b8.done && n < 40) begin @(negedge clk); n++; end
    chk("hs_first_lat", 64'(n), 64'd9);
    chk("hs_first_res", get_res(8), 64'd42);
    n = 0;
    @(negedge clk); n++;
    while (!b8.done && n < 40) begin @(negedge clk); n++; end
    drive(8, 1'b0, 1'b0, 2, 3);
    chk("hs_gap",       64'(n), 64'd10);
    chk("hs_second_res", get_res(8), 64'd6);

    // Asynchronous reset mid-CALC
    @(negedge clk); drive(8, 1'b1, 1'b0, 100, 100);
    @(negedge clk); drive(8, 1'b0, 1'b0, 100, 100);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   64'(b8.busy), 64'd0);
    chk("arst_done",   64'(b8.done), 64'd0);
    chk("arst_result", get_res(8),   64'd0);
    n = 0;
    repeat (12) begin @(negedge clk); if (b8.done) n++; end
    chk("arst_no_done", 64'(n), 64'd0);
    rst_n = 1'b1;
    op("u5x5", 8, 1'b0, 5, 5, r, e, bc);
    chk("u5x5", r, 64'd25);

    // WIDTH=4
    op("w4_sm8xm8", 4, 1'b1, 32'h8, 32'h8, r, e, bc);
    chk("w4_sm8xm8", r, 64'h40);
    chk("w4_lat",    64'(e), 64'd5);
    op("w4_u15x15", 4, 1'b0, 32'hF, 32'hF, r, e, bc);
    chk("w4_u15x15", r, 64'hE1);

    // WIDTH=16 randomized against a reference product
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [31:0] exp;
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 16'h8000; b = 16'h8000; s = 1'b1; end
      if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; s = 1'b0; end
      if (s) exp = 32'($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b}));
      else   exp = {16'd0, a} * {16'd0, b};
      op("w16_rand", 16, s, 32'(a), 32'(b), r, e, bc);
      chk($sformatf("w16_rand%0d", i), r, 64'(exp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_add_mult_p.md
# shift_add_mult_p

Parametrised sequential shift-and-add multiplier: the WIDTH-generic, signed-capable successor to the lab 8×8 shift-add multiplier. It processes one multiplier bit per clock and uses an explicit start/busy/done handshake, so a controlling FSM or testbench can issue operations on demand instead of relying on free-running recomputation. Latency is fixed, and the result register holds its value between operations.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  request a multiply; sampled on rising edge, accepted only when idle
- sgn  in  1  operand mode, sampled with start: 1 = two's-complement signed, 0 = unsigned
- x  in  WIDTH  multiplicand, sampled with accepted start
- y  in  WIDTH  multiplier, sampled with accepted start
- busy  out  1  high while an operation is in progress (states CALC and SIGN)
- done  out  1  single-cycle pulse; result is valid in this cycle
- result  out  2*WIDTH  product; held until the next done

## Operation
- Three-state FSM: IDLE, CALC, SIGN. Reset state is IDLE.
- Reset values: busy=0, done=0, result=0. Internal accumulator, operand registers and counter are all cleared.
- IDLE, on start=1:
  - Latch the operand magnitudes: mcand = |x| and mplr = |y| when sgn=1, otherwise x and y unchanged.
  - Latch neg = sgn & (x[MSB] ^ y[MSB]).
  - Clear acc (2*WIDTH bits) and count; go to CALC.
  - start=0: stay in IDLE.
- Magnitude width: |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits, so no extra bit is required. mcand is stored zero-extended to 2*WIDTH.
- CALC, every cycle:
  - If mplr[0]: acc <= acc + mcand. The sum is modulo 2^(2W); it never overflows for legal inputs.
  - mcand <<= 1; mplr >>= 1; count++.
  - When count == WIDTH−1, go to SIGN. Exactly WIDTH CALC cycles.
- SIGN (one cycle): result <= neg ? (~acc + 1) : acc; done <= 1; go to IDLE.
- done deasserts on the next edge unconditionally.
- start while busy=1 is ignored. It is not queued, and x/y/sgn changes have no effect.
- start in the cycle done=1 (state already IDLE) is accepted, giving back-to-back operation.
- Asynchronous reset mid-operation:
  - Immediately returns the FSM to IDLE with busy=0, done=0, result=0.
  - The partial product is discarded.
  - The first edge after rst_n rises may accept start.
- Range: the signed product of two WIDTH-bit values always fits in 2*WIDTH bits, e.g. (−128)×(−128) = +16384 for WIDTH=8.

## Timing
- Accepting edge k (state IDLE, start=1): busy=1 after edge k.
- CALC occupies edges k+1 .. k+WIDTH.
- SIGN occurs at edge k+WIDTH+1. After that edge: done=1, result valid, busy=0.
- Latency: start edge to done edge = WIDTH+1 clocks (9 for WIDTH=8).
- Throughput: one operation per WIDTH+2 clocks when start is held high continuously.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- WIDTH=8, sgn=0, x=13, y=11, one-cycle start: busy high for 9 cycles, then done pulses once with result=143 (0x008F), 9 edges after start. result holds 0x008F through 5 idle cycles.
- WIDTH=8 unsigned corner cases:
  - 255×255: result=0xFE01.
  - 0×200 and 200×0: result=0x0000.
  - 1×1: result=0x0001.
- WIDTH=8, sgn=1:
  - −3×5: result=0xFFF1.
  - −128×−128: result=0x4000.
  - −128×127: result=0xC080.
  - 127×−1: result=0xFF81.
- Handshake:
  - Pulse start with x=7, y=6.
  - Assert start again with x=9, y=9 at edge k+3: no effect; done yields 42.
  - Hold start high with x=2, y=3: a new operation begins on the done cycle; the second done arrives 10 edges after the first with result=6.
- Reset:
  - Drop rst_n asynchronously mid-CALC, 4 edges after start: busy, done and result go to 0 at once, with no done pulse.
  - After release, 5×5 completes with result=25.
- Parameter sweep:
  - WIDTH=4: −8×−8 gives 0x40; 15×15 unsigned gives 0xE1; latency is 5 edges.
  - WIDTH=16: 1000 randomized signed and unsigned operations match a reference model.
